// File: rtl/miriscv_decode_queue_if.sv
// miriscv_decode_queue_if: fetch-side input and decoded-bundle output handshake of the decode queue
interface miriscv_decode_queue_if #(parameter int CNT_WIDTH = 16);
  logic                 flush;
  logic [31:0]          instr;
  logic [31:0]          pc;
  logic                 in_valid;
  logic                 in_ready;
  logic                 out_valid;
  logic                 out_ready;
  logic [31:0]          out_instr;
  logic [31:0]          out_pc;
  logic [1:0]           ex_op_a_sel;
  logic [2:0]           ex_op_b_sel;
  logic [4:0]           alu_op;
  logic                 mdu_req;
  logic [2:0]           mdu_op;
  logic                 mem_req;
  logic                 mem_we;
  logic [2:0]           mem_size;
  logic                 gpr_we_a;
  logic                 wb_src_sel;
  logic                 illegal_instr;
  logic                 branch;
  logic                 jal;
  logic                 jalr;
  logic [CNT_WIDTH-1:0] illegal_cnt;
  modport master (
    output flush, instr, pc, in_valid, out_ready,
    input  in_ready, out_valid, out_instr, out_pc, ex_op_a_sel, ex_op_b_sel, alu_op, mdu_req, mdu_op,
           mem_req, mem_we, mem_size, gpr_we_a, wb_src_sel, illegal_instr, branch, jal, jalr, illegal_cnt
  );
  modport slave (
    input  flush, instr, pc, in_valid, out_ready,
    output in_ready, out_valid, out_instr, out_pc, ex_op_a_sel, ex_op_b_sel, alu_op, mdu_req, mdu_op,
           mem_req, mem_we, mem_size, gpr_we_a, wb_src_sel, illegal_instr, branch, jal, jalr, illegal_cnt
  );
endinterface

// File: rtl/miriscv_decode_queue.sv
// miriscv_decode_queue: FIFO-buffered RV32I(M) decode stage with a registered handshaked output bundle
module miriscv_decode_queue #(
  parameter int DEPTH     = 4,
  parameter bit M_EXT     = 1'b0,
  parameter int CNT_WIDTH = 16
) (
  input logic clk_i,
  input logic rst_i,
  miriscv_decode_queue_if.slave q
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [1:0] OP_A_CURR_PC = 2'd1;
  localparam logic [1:0] OP_A_ZERO    = 2'd2;
  localparam logic [2:0] OP_B_IMM_I   = 3'd1;
  localparam logic [2:0] OP_B_IMM_U   = 3'd2;
  localparam logic [2:0] OP_B_IMM_S   = 3'd3;
  localparam logic [2:0] OP_B_INCR    = 3'd4;
  localparam logic       WB_LSU_DATA  = 1'b1;
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [1:0]  op_a;
    logic [2:0]  op_b;
    logic [4:0]  alu;
    logic        mdu_req;
    logic [2:0]  mdu_op;
    logic        mem_req;
    logic        mem_we;
    logic [2:0]  mem_size;
    logic        gpr_we;
    logic        wb;
    logic        illegal;
    logic        branch;
    logic        jal;
    logic        jalr;
  } bundle_t;
  localparam bundle_t RST = '{mem_size: 3'd2, default: '0};
  logic [31:0]          instr_mem [DEPTH];
  logic [31:0]          pc_mem [DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [AW:0]          count;
  logic                 push, pop, ok, valid;
  logic [31:0]          hi;
  logic [2:0]           f3;
  logic [6:0]           f7;
  logic [CNT_WIDTH-1:0] cnt;
  bundle_t              d, b;
  assign q.in_ready = count < (AW+1)'(DEPTH);
  assign push = q.in_valid & q.in_ready;
  assign pop = (count != '0) & (~valid | q.out_ready);
  assign hi = instr_mem[rd_ptr];
  assign f3 = hi[14:12];
  assign f7 = hi[31:25];
  always_comb begin
    d = RST;
    d.instr = hi;
    d.pc = pc_mem[rd_ptr];
    ok = 1'b0;
    case (hi[6:2])
      5'b01101: begin ok = 1'b1; d.op_a = OP_A_ZERO; d.op_b = OP_B_IMM_U; d.gpr_we = 1'b1; end
      5'b00101: begin ok = 1'b1; d.op_a = OP_A_CURR_PC; d.op_b = OP_B_IMM_U; d.gpr_we = 1'b1; end
      5'b11011: begin ok = 1'b1; d.op_a = OP_A_CURR_PC; d.op_b = OP_B_INCR; d.gpr_we = 1'b1; d.jal = 1'b1; end
      5'b11001: begin ok = f3 == 3'b000; d.op_a = OP_A_CURR_PC; d.op_b = OP_B_INCR; d.gpr_we = 1'b1; d.jalr = 1'b1; end
      5'b11000: begin ok = f3[2:1] != 2'b01; d.alu = {2'b11, f3}; d.branch = 1'b1; end
      5'b00000: begin
        ok = f3 != 3'b011 && f3[2:1] != 2'b11;
        d.op_b = OP_B_IMM_I;
        d.mem_req = 1'b1;
        d.gpr_we = 1'b1;
        d.wb = WB_LSU_DATA;
        d.mem_size = f3;
      end
      5'b01000: begin
        ok = !f3[2] && f3 != 3'b011;
        d.op_b = OP_B_IMM_S;
        d.mem_req = 1'b1;
        d.mem_we = 1'b1;
        d.mem_size = f3;
      end
      5'b00100: begin
        ok = f3 == 3'b001 ? f7 == 7'h00 : f3 == 3'b101 ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1;
        d.op_b = OP_B_IMM_I;
        d.alu = {1'b0, f3 == 3'b101 && f7[5], f3};
        d.gpr_we = 1'b1;
      end
      5'b01100: begin
        ok = f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101)) || (M_EXT && f7 == 7'h01);
        d.alu = f7 == 7'h01 ? 5'd0 : {1'b0, f7[5], f3};
        d.mdu_req = f7 == 7'h01;
        d.mdu_op = f7 == 7'h01 ? f3 : 3'd0;
        d.gpr_we = 1'b1;
      end
      5'b00011: ok = f3 == 3'b000;
      5'b11100: ok = hi == 32'h0000_0073 || hi == 32'h0010_0073;
      default:  ok = 1'b0;
    endcase
    if (!ok || hi[1:0] != 2'b11) begin
      d = RST;
      d.instr = hi;
      d.pc = pc_mem[rd_ptr];
      d.illegal = 1'b1;
    end
  end
  always_ff @(posedge clk_i)
    if (push) begin
      instr_mem[wr_ptr] <= q.instr;
      pc_mem[wr_ptr] <= q.pc;
    end
  always_ff @(posedge clk_i) begin
    if (rst_i || q.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      valid <= 1'b0;
      b <= RST;
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
      valid <= pop | (valid & ~q.out_ready);
      b <= pop ? d : b;
    end
    cnt <= rst_i ? '0 : cnt + CNT_WIDTH'(valid & q.out_ready & b.illegal & ~&cnt);
  end
  assign q.out_valid = valid;
  assign q.out_instr = b.instr;
  assign q.out_pc = b.pc;
  assign q.ex_op_a_sel = b.op_a;
  assign q.ex_op_b_sel = b.op_b;
  assign q.alu_op = b.alu;
  assign q.mdu_req = b.mdu_req;
  assign q.mdu_op = b.mdu_op;
  assign q.mem_req = b.mem_req;
  assign q.mem_we = b.mem_we;
  assign q.mem_size = b.mem_size;
  assign q.gpr_we_a = b.gpr_we;
  assign q.wb_src_sel = b.wb;
  assign q.illegal_instr = b.illegal;
  assign q.branch = b.branch;
  assign q.jal = b.jal;
  assign q.jalr = b.jalr;
  assign q.illegal_cnt = cnt;
endmodule
